// File: rtl/led_pkg.sv
// Shared constants and types for the LED comet-trail PWM output stage.
// Holds the default channel count and brightness width, the brightness
// type at the default width and its full-scale value.
package led_pkg;

    localparam int unsigned LED_N_LEDS   = 8;
    localparam int unsigned LED_PWM_BITS = 8;

    typedef logic [LED_PWM_BITS-1:0] bright_t;

    localparam bright_t BRIGHT_MAX = '1;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel of the comet-trail PWM stage.
// Keeps the live brightness (set to full on a lit pattern bit, decayed by a
// right shift on each step otherwise) and a shadow copy that is only
// refreshed on load_i, so a period's duty never changes mid-period.
// Optional build macro LED_GAMMA_EN applies a square-law gamma to the
// shadow value before the compare.
//
// Ports:
//   clk_i         system clock
//   sys_rst_i     synchronous active-high reset
//   en_i          output enable (gates the LED bit)
//   step_i        one-cycle pattern step strobe
//   pattern_bit_i this channel's pattern bit, valid with step_i
//   load_i        shadow load strobe (PWM wrap, or every cycle when disabled)
//   pwm_cnt_i     shared PWM counter
//   led_o         registered PWM drive
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS    = LED_PWM_BITS,
    parameter int unsigned DECAY_SHIFT = 1
) (
    input  logic                clk_i,
    input  logic                sys_rst_i,
    input  logic                en_i,
    input  logic                step_i,
    input  logic                pattern_bit_i,
    input  logic                load_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);

    logic [PWM_BITS-1:0] bright;
    logic [PWM_BITS-1:0] shadow;
    logic [PWM_BITS-1:0] duty;

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] shadow_sq;

    // Square-law gamma: keep the upper half of the double-width product.
    always_comb begin
        shadow_sq = {{PWM_BITS{1'b0}}, shadow} * {{PWM_BITS{1'b0}}, shadow};
        duty      = shadow_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        duty = shadow;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            bright <= '0;
            shadow <= '0;
            led_o  <= 1'b0;
        end else begin
            if (step_i) begin
                if (pattern_bit_i) begin
                    bright <= '1;
                end else begin
                    bright <= bright >> DECAY_SHIFT;
                end
            end
            // Shadow takes the pre-step value; a coincident step lands next period.
            if (load_i) begin
                shadow <= bright;
            end
            led_o <= en_i & (pwm_cnt_i < duty);
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail PWM output stage for the 8-bit Knight Rider pattern.
// Owns the shared free-running PWM counter, the period pulse and the enable
// gating; one led_pwm_channel per LED handles brightness, decay and compare.
// Optional build macro LED_GAMMA_EN selects square-law gamma in the channels.
//
// Ports:
//   clk_i      system clock
//   sys_rst_i  synchronous active-high reset
//   en_i       output enable; low forces led_o/period_o to 0 and pwm_cnt to 0
//   step_i     one-cycle strobe marking a valid pattern_i
//   pattern_i  Knight Rider pattern, sampled only with step_i
//   led_o      registered PWM LED drive
//   period_o   one-cycle pulse on the first cycle of each PWM period
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS      = LED_N_LEDS,
    parameter int unsigned PWM_BITS    = LED_PWM_BITS,
    parameter int unsigned DECAY_SHIFT = 1
) (
    input  logic              clk_i,
    input  logic              sys_rst_i,
    input  logic              en_i,
    input  logic              step_i,
    input  logic [N_LEDS-1:0] pattern_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              period_o
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                cnt_at_max;
    logic                shadow_load;

    always_comb begin
        cnt_at_max  = (pwm_cnt == '1);
        // While disabled every cycle counts as a wrap, so the shadow tracks bright.
        shadow_load = cnt_at_max | ~en_i;
    end

    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            pwm_cnt  <= '0;
            period_o <= 1'b0;
        end else begin
            if (en_i) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pwm_cnt <= '0;
            end
            period_o <= cnt_at_max & en_i;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS    (PWM_BITS),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_chan (
            .clk_i         (clk_i),
            .sys_rst_i     (sys_rst_i),
            .en_i          (en_i),
            .step_i        (step_i),
            .pattern_bit_i (pattern_i[i]),
            .load_i        (shadow_load),
            .pwm_cnt_i     (pwm_cnt),
            .led_o         (led_o[i])
        );
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed self-checking bench for led_trail_pwm (default parameters).
// Duties are measured as high-cycle counts of each led_o bit over one
// 256-cycle PWM period aligned to period_o.
module tb_led_trail_pwm;

    logic       clk_i;
    logic       sys_rst_i;
    logic       en_i;
    logic       step_i;
    logic [7:0] pattern_i;
    logic [7:0] led_o;
    logic       period_o;

    int n_checks = 0;
    int n_fail   = 0;
    int hits[8];

    led_trail_pwm #(
        .N_LEDS      (8),
        .PWM_BITS    (8),
        .DECAY_SHIFT (1)
    ) dut (
        .clk_i     (clk_i),
        .sys_rst_i (sys_rst_i),
        .en_i      (en_i),
        .step_i    (step_i),
        .pattern_i (pattern_i),
        .led_o     (led_o),
        .period_o  (period_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected measured duty for a given shadow brightness.
    function automatic int exp_duty(input int b);
`ifdef LED_GAMMA_EN
        case (b)
            255:     return 254;
            127:     return 63;
            63:      return 15;
            default: return 0;
        endcase
`else
        return b;
`endif
    endfunction

    // Step pulse driven for exactly one clock.
    task automatic do_step(input logic [7:0] pat);
        step_i    = 1'b1;
        pattern_i = pat;
        @(negedge clk_i);
        step_i    = 1'b0;
        pattern_i = 8'h00;
    endtask

    // Sample n cycles from now: no LED activity, pulses every 256 from sample 0.
    task automatic run_idle(input string tag, input int n);
        int led_hi = 0;
        int pulses = 0;
        int first  = -1;
        for (int k = 0; k < n; k++) begin
            if (led_o != 8'h00) led_hi++;
            if (period_o) begin
                pulses++;
                if (first < 0) first = k;
            end
            @(negedge clk_i);
        end
        check_eq({tag, "_led_hi"}, led_hi, 0);
        check_eq({tag, "_pulses"}, pulses, 2);
        check_eq({tag, "_first_pulse"}, first, 256);
    endtask

    // Advance to the next period_o sample; optionally require dark LEDs meanwhile.
    task automatic wait_pulse(input string tag, input bit want_dark);
        int led_hi = 0;
        bit found  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (period_o) begin
                found = 1'b1;
                break;
            end
            if (led_o != 8'h00) led_hi++;
            @(negedge clk_i);
        end
        check_eq({tag, "_found"}, int'(found), 1);
        if (want_dark) check_eq({tag, "_dark"}, led_hi, 0);
    endtask

    // Called at a period_o sample: measure one period, end at the next pulse.
    task automatic measure(input string tag);
        int early = 0;
        for (int i = 0; i < 8; i++) hits[i] = 0;
        for (int j = 1; j <= 256; j++) begin
            @(negedge clk_i);
            for (int i = 0; i < 8; i++) hits[i] += int'(led_o[i]);
            if (j < 256 && period_o) early++;
        end
        check_eq({tag, "_early_pulse"}, early, 0);
        check_eq({tag, "_end_pulse"}, int'(period_o), 1);
    endtask

    initial begin
        int led_hi;
        int per_hi;

        sys_rst_i = 1'b1;
        en_i      = 1'b1;
        step_i    = 1'b0;
        pattern_i = 8'h00;
        repeat (3) @(negedge clk_i);
        check_eq("rst_led", int'(led_o), 0);
        check_eq("rst_period", int'(period_o), 0);
        sys_rst_i = 1'b0;
        run_idle("idle", 600);

        // Single step mid-period: no change until the wrap, then full duty.
        wait_pulse("s1_sync", 1'b0);
        repeat (100) @(negedge clk_i);
        do_step(8'h01);
        wait_pulse("s1_hold", 1'b1);
        measure("s1");
        check_eq("s1_led0", hits[0], exp_duty(255));
        check_eq("s1_led1", hits[1], 0);
        check_eq("s1_led7", hits[7], 0);

        // Decay trail.
        repeat (50) @(negedge clk_i);
        do_step(8'h02);
        wait_pulse("tr2", 1'b0);
        repeat (50) @(negedge clk_i);
        do_step(8'h04);
        wait_pulse("tr3", 1'b0);
        measure("tr");
        check_eq("tr_led0", hits[0], exp_duty(63));
        check_eq("tr_led1", hits[1], exp_duty(127));
        check_eq("tr_led2", hits[2], exp_duty(255));
        check_eq("tr_led3", hits[3], 0);
        step_i    = 1'b1;
        pattern_i = 8'h00;
        repeat (8) @(negedge clk_i);
        step_i    = 1'b0;
        wait_pulse("tr_zero", 1'b0);
        measure("trz");
        check_eq("trz_led0", hits[0], 0);
        check_eq("trz_led1", hits[1], 0);
        check_eq("trz_led2", hits[2], 0);

        // Step exactly in the wrap cycle (pwm_cnt == 255).
        repeat (255) @(negedge clk_i);
        do_step(8'h80);
        check_eq("co_pulse", int'(period_o), 1);
        measure("co_a");
        check_eq("co_a_led7", hits[7], 0);
        measure("co_b");
        check_eq("co_b_led7", hits[7], exp_duty(255));

        // Mid-operation reset with LED7 lit.
        repeat (10) @(negedge clk_i);
        check_eq("mr_lit", int'(led_o[7]), 1);
        sys_rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("mr_led", int'(led_o), 0);
        check_eq("mr_period", int'(period_o), 0);
        repeat (2) @(negedge clk_i);
        sys_rst_i = 1'b0;
        run_idle("mr_idle", 600);

        // Enable gating.
        wait_pulse("en_sync", 1'b0);
        repeat (20) @(negedge clk_i);
        do_step(8'h10);
        en_i = 1'b0;
        @(negedge clk_i);
        led_hi = 0;
        per_hi = 0;
        for (int k = 0; k < 100; k++) begin
            if (led_o != 8'h00) led_hi++;
            if (period_o) per_hi++;
            @(negedge clk_i);
        end
        check_eq("en_off_led", led_hi, 0);
        check_eq("en_off_period", per_hi, 0);
        en_i = 1'b1;
        check_eq("en_on_led0", int'(led_o), 0);
        measure("en_on");
        check_eq("en_on_led4", hits[4], exp_duty(255));
        check_eq("en_on_led0", hits[0], 0);

        // Decay sequence 255 -> 127 -> 63 on LED0.
        do_step(8'h01);
        wait_pulse("gm1", 1'b0);
        measure("gm1");
        check_eq("gm1_led0", hits[0], exp_duty(255));
        do_step(8'h00);
        wait_pulse("gm2", 1'b0);
        measure("gm2");
        check_eq("gm2_led0", hits[0], exp_duty(127));
        do_step(8'h00);
        wait_pulse("gm3", 1'b0);
        measure("gm3");
        check_eq("gm3_led0", hits[0], exp_duty(63));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream output stage for the 8-bit Knight Rider pattern. It turns the hard on/off LED pattern into a PWM-driven "comet trail".
- Each LED lights at full brightness when its pattern bit is set. After the bit clears, brightness halves on every pattern step.
- Runs on the fast system clock. The slow pattern update is marked by a one-cycle step strobe.
- The block drives the board LED pins directly.

Parameters:
- N_LEDS, 8, number of LED channels; equals the pattern width.
- PWM_BITS, 8, width of the brightness value and the PWM counter; PWM period = 2^PWM_BITS cycles.
- DECAY_SHIFT, 1, right-shift applied to a non-lit LED's brightness on each step.

Ports:
- clk_i  input  1  system clock.
- sys_rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  output enable.
- step_i  input  1  one-cycle strobe; pattern_i is valid in this cycle.
- pattern_i  input  N_LEDS  Knight Rider pattern, sampled only when step_i=1.
- led_o  output  N_LEDS  registered PWM LED drive.
- period_o  output  1  one-cycle pulse on the first cycle of each PWM period.

Behaviour:
- Clock and reset (already decided): one clock, clk_i; reset sys_rst_i is synchronous and active-high.
- Reset values: pwm_cnt=0, bright[i]=0, shadow[i]=0, led_o=0, period_o=0. A reset mid-operation clears all state on the next edge; no residual trail.
- pwm_cnt:
  - PWM_BITS-wide free-running counter; wraps max->0.
  - The wrap cycle is the cycle where pwm_cnt==max.
  - Holds at 0 while en_i=0.
- Brightness update, on cycles with step_i=1, for each i:
  - if pattern_i[i]=1, bright[i] <= all-ones;
  - else bright[i] <= bright[i] >> DECAY_SHIFT.
  - No update when step_i=0. Repeated steps with the bit clear drive the value to 0 and hold it there.
- Shadow load (glitch-free duty):
  - shadow[i] <= bright[i] only in the wrap cycle, using the pre-update bright value.
  - If step_i coincides with the wrap cycle, the new brightness appears one period later.
  - A step mid-period never alters the current period's duty.
- Output:
  - led_o[i] <= en_i & (pwm_cnt < duty[i]), registered, one-cycle latency from pwm_cnt.
  - duty[i] = shadow[i] (or its gamma value, see Optional Feature).
  - Full scale (255) gives 255/256 on-time; 0 gives always off.
- period_o <= (pwm_cnt==max) & en_i. It is high in the cycle where pwm_cnt reads 0.
- en_i=0: led_o=0 and period_o=0 from the next cycle; pwm_cnt forced to 0. bright and shadow still update, with the shadow load treated as a wrap every cycle.
- en_i rising: pwm_cnt starts from 0.
- No back-pressure. Each step_i pulse is consumed in the cycle it arrives. Back-to-back steps are legal and each applies a decay.

Optional Feature:
- Macro LED_GAMMA_EN.
- Defined: duty[i] = (shadow[i]*shadow[i]) >> PWM_BITS, a square-law gamma for perceptual linearity. It is computed combinationally from the shadow value, with no added latency. Examples: 255->254, 127->63, 63->15, 1->0.
- Undefined: duty[i] = shadow[i] (linear).

Decomposition:
- Package led_pkg holds:
  - LED_N_LEDS and LED_PWM_BITS default constants;
  - typedef bright_t (logic [PWM_BITS-1:0]);
  - BRIGHT_MAX constant (all-ones).
- Sub-module led_pwm_channel, one instance per LED via generate, contains:
  - the bright and shadow registers;
  - the decay logic;
  - the optional gamma;
  - the comparator against the shared pwm_cnt;
  - the registered led bit.
- The top level owns pwm_cnt, period_o and the enable gating.

Test Plan (defaults, en_i=1 unless stated):
- Reset: hold sys_rst_i 3 cycles, release, no steps for 600 cycles -> led_o==0 throughout; period_o pulses every 256 cycles.
- Single step: step_i with pattern_i=0x01 mid-period -> led_o unchanged until the wrap; the next full period has led_o[0] high 255 of 256 cycles and other bits 0.
- Decay trail: steps 0x01, 0x02, 0x04, each in a separate period -> after the third load, duty LED0=63, LED1=127, LED2=255 (high-cycle counts per period); a further 8 steps of 0x00 -> all duties 0.
- Coincident events: step_i=0x80 exactly in the wrap cycle -> led_o[7] stays 0 for the following period and shows 255 the period after. A mid-operation reset with LEDs lit -> led_o=0 on the cycle after reset, and no trail after release.
- Enable: deassert en_i for 100 cycles -> led_o=0, period_o=0; reassert -> pwm_cnt restarts at 0 and period_o pulses 256 cycles later.
- With LED_GAMMA_EN: decay sequence 0xFF->127->63 -> measured duties 254, 63, 15.
